// File: rtl/reset_conditioner.sv
// reset_conditioner: turns a raw asynchronous active-low reset into a clean
// active-high fabric reset. Assertion is immediate, release is synchronised
// to clk and then stretched by HOLD_CYCLES.
// Optional feature macro: RESET_CONDITIONER_SOFT_EN enables the synchronous
// software reset request and the saturating reset_count register.
module reset_conditioner #(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       sw_reset_req,
  output logic       rst_out,
  output logic       rst_out_n,
  output logic       ready,
  output logic       release_pulse,
  output logic [7:0] reset_count
);

  localparam int CW = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_SYNC = 2'd0,
    ST_HOLD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t                 state_r;
  state_t                 state_nxt_s;
  logic [SYNC_STAGES-1:0] sync_r;
  logic [CW-1:0]          cnt_r;
  logic [CW-1:0]          cnt_nxt_s;
  logic                   rst_out_r;
  logic                   rst_out_n_r;
  logic                   ready_r;
  logic                   pulse_r;
  logic                   rst_nxt_s;
  logic                   ready_nxt_s;
  logic                   pulse_nxt_s;
  logic                   count_inc_s;
  logic                   soft_req_s;

`ifdef RESET_CONDITIONER_SOFT_EN
  assign soft_req_s = sw_reset_req;
`else
  // Software path disabled: the request port is kept but has no effect.
  logic unused_s;
  assign soft_req_s = 1'b0;
  assign unused_s   = ^{sw_reset_req, count_inc_s};
`endif

  // Release synchroniser: shifts in 1s, cleared asynchronously by reset_n.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], 1'b1};
    end
  end

  // Next-state and next-output logic for the SYNC/HOLD/RUN sequence.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    rst_nxt_s   = rst_out_r;
    ready_nxt_s = ready_r;
    pulse_nxt_s = 1'b0;
    count_inc_s = 1'b0;
    case (state_r)
      ST_SYNC: begin
        rst_nxt_s   = 1'b1;
        ready_nxt_s = 1'b0;
        cnt_nxt_s   = '0;
        if (sync_r[SYNC_STAGES-1]) begin
          state_nxt_s = ST_HOLD;
        end else begin
          state_nxt_s = ST_SYNC;
        end
      end
      ST_HOLD: begin
        rst_nxt_s   = 1'b1;
        ready_nxt_s = 1'b0;
        if (soft_req_s) begin
          // A request during HOLD restarts the hold window without counting.
          cnt_nxt_s = '0;
        end else if (cnt_r == HOLD_LAST) begin
          state_nxt_s = ST_RUN;
          rst_nxt_s   = 1'b0;
          ready_nxt_s = 1'b1;
          pulse_nxt_s = 1'b1;
        end else begin
          // Stops at HOLD_LAST, so the counter can never wrap.
          cnt_nxt_s = cnt_r + CW'(1);
        end
      end
      ST_RUN: begin
        if (soft_req_s) begin
          state_nxt_s = ST_HOLD;
          cnt_nxt_s   = '0;
          rst_nxt_s   = 1'b1;
          ready_nxt_s = 1'b0;
          count_inc_s = 1'b1;
        end else begin
          rst_nxt_s   = 1'b0;
          ready_nxt_s = 1'b1;
        end
      end
      default: begin
        state_nxt_s = ST_SYNC;
        cnt_nxt_s   = '0;
        rst_nxt_s   = 1'b1;
        ready_nxt_s = 1'b0;
      end
    endcase
  end

  // State, hold counter and registered outputs; reset_n clears them at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_SYNC;
      cnt_r       <= '0;
      rst_out_r   <= 1'b1;
      rst_out_n_r <= 1'b0;
      ready_r     <= 1'b0;
      pulse_r     <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      rst_out_r   <= rst_nxt_s;
      rst_out_n_r <= ~rst_nxt_s;
      ready_r     <= ready_nxt_s;
      pulse_r     <= pulse_nxt_s;
    end
  end

`ifdef RESET_CONDITIONER_SOFT_EN
  logic [7:0] reset_count_r;

  // Saturating count of software resets taken from RUN.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      reset_count_r <= 8'h00;
    end else if (count_inc_s && (reset_count_r != 8'hFF)) begin
      reset_count_r <= reset_count_r + 8'h01;
    end else begin
      reset_count_r <= reset_count_r;
    end
  end

  assign reset_count = reset_count_r;
`else
  assign reset_count = 8'h00;
`endif

  assign rst_out       = rst_out_r;
  assign rst_out_n     = rst_out_n_r;
  assign ready         = ready_r;
  assign release_pulse = pulse_r;

endmodule

// File: tb/tb_reset_conditioner.sv
// Self-checking bench for reset_conditioner: power-on release, asynchronous
// assertion/glitch, soft reset sequences, saturation and parameter corners.
module tb_reset_conditioner;

  typedef struct packed {
    logic       rst;
    logic       rst_n;
    logic       rdy;
    logic       pulse;
    logic [7:0] cnt;
  } obs_t;

  typedef struct {
    logic rn;
    logic req;
    obs_t exp;
  } vec_t;

`ifdef RESET_CONDITIONER_SOFT_EN
  localparam bit SOFT = 1'b1;
`else
  localparam bit SOFT = 1'b0;
`endif

  logic       clk;
  logic       reset_n;
  logic       sw_reset_req;
  logic       rst_a, rstn_a, rdy_a, pls_a;
  logic       rst_b, rstn_b, rdy_b, pls_b;
  logic       rst_c, rstn_c, rdy_c, pls_c;
  logic       rst_d, rstn_d, rdy_d, pls_d;
  logic [7:0] cnt_a, cnt_b, cnt_c, cnt_d;
  obs_t       obs_a, obs_b, obs_c, obs_d;

  int   n_chk;
  int   n_pass;
  obs_t exp_q[$];
  int   exp_edge_q[$];
  vec_t tbl[26];

  reset_conditioner dut_a (
    .clk(clk), .reset_n(reset_n), .sw_reset_req(sw_reset_req),
    .rst_out(rst_a), .rst_out_n(rstn_a), .ready(rdy_a),
    .release_pulse(pls_a), .reset_count(cnt_a)
  );

  reset_conditioner #(.SYNC_STAGES(2), .HOLD_CYCLES(4)) dut_b (
    .clk(clk), .reset_n(reset_n), .sw_reset_req(sw_reset_req),
    .rst_out(rst_b), .rst_out_n(rstn_b), .ready(rdy_b),
    .release_pulse(pls_b), .reset_count(cnt_b)
  );

  reset_conditioner #(.SYNC_STAGES(4), .HOLD_CYCLES(1)) dut_c (
    .clk(clk), .reset_n(reset_n), .sw_reset_req(sw_reset_req),
    .rst_out(rst_c), .rst_out_n(rstn_c), .ready(rdy_c),
    .release_pulse(pls_c), .reset_count(cnt_c)
  );

  reset_conditioner #(.SYNC_STAGES(4), .HOLD_CYCLES(65535)) dut_d (
    .clk(clk), .reset_n(reset_n), .sw_reset_req(sw_reset_req),
    .rst_out(rst_d), .rst_out_n(rstn_d), .ready(rdy_d),
    .release_pulse(pls_d), .reset_count(cnt_d)
  );

  assign obs_a = {rst_a, rstn_a, rdy_a, pls_a, cnt_a};
  assign obs_b = {rst_b, rstn_b, rdy_b, pls_b, cnt_b};
  assign obs_c = {rst_c, rstn_c, rdy_c, pls_c, cnt_c};
  assign obs_d = {rst_d, rstn_d, rdy_d, pls_d, cnt_d};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic obs_t mk(input logic r, input logic rd, input logic p,
                              input logic [7:0] c);
    obs_t o;
    o.rst   = r;
    o.rst_n = ~r;
    o.rdy   = rd;
    o.pulse = p;
    o.cnt   = c;
    return o;
  endfunction

  // Expected outputs j cycles into a soft-reset sequence that releases at j_fall.
  function automatic obs_t soft_exp(input int j_fall, input int j, input logic [7:0] c);
    if (SOFT) return mk(j < j_fall, j >= j_fall, j == j_fall, c);
    else      return mk(1'b0, 1'b1, 1'b0, 8'h00);
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] got,
                     input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s[%0d]: got %h, required %h", name, idx, got, want);
  endtask

  // Drive one cycle, queue the expectation, compare after the edge.
  task automatic cyc(input string name, input int idx, input int sel,
                     input logic rn, input logic req, input obs_t e);
    obs_t got;
    obs_t want;
    reset_n      = rn;
    sw_reset_req = req;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got  = (sel == 0) ? obs_a : obs_b;
    want = exp_q.pop_front();
    chk(name, idx, 32'(got), 32'(want));
  endtask

  task automatic soft_pulse(input string name, input logic [7:0] c);
    for (int j = 0; j < 6; j++) begin
      cyc(name, j, 1, 1'b1, (j == 0), soft_exp(4, j, c));
    end
  endtask

  initial begin
    int   c_edge;
    int   d_edge;
    logic c_pulse;
    logic d_pulse;
    logic [7:0] sat_c;
    logic held_req[20];

    n_chk        = 0;
    n_pass       = 0;
    reset_n      = 1'b1;
    sw_reset_req = 1'b0;
    #1 reset_n   = 1'b0;

    // Power-on table: 5 cycles in reset, then release at edge k = i - 4.
    for (int i = 0; i < 26; i++) begin
      tbl[i].rn  = (i >= 5);
      tbl[i].req = 1'b0;
      if (i < 5) tbl[i].exp = mk(1'b1, 1'b0, 1'b0, 8'h00);
      else       tbl[i].exp = mk((i - 4) < 19, (i - 4) >= 19, (i - 4) == 19, 8'h00);
    end
    for (int i = 0; i < 26; i++) begin
      cyc("power_on", i, 0, tbl[i].rn, tbl[i].req, tbl[i].exp);
    end

    // Mid-cycle glitch in RUN: immediate assertion, then full restart.
    reset_n = 1'b0;
    #1;
    chk("async_assert_a", 0, 32'(obs_a), 32'(mk(1'b1, 1'b0, 1'b0, 8'h00)));
    chk("async_assert_b", 0, 32'(obs_b), 32'(mk(1'b1, 1'b0, 1'b0, 8'h00)));
    #2 reset_n = 1'b1;
    for (int k = 1; k <= 21; k++) begin
      cyc("glitch_release", k, 0, 1'b1, 1'b0, mk(k < 19, k >= 19, k == 19, 8'h00));
    end

    // Single soft reset pulse on the HOLD_CYCLES=4 instance.
    soft_pulse("soft_pulse", SOFT ? 8'd1 : 8'd0);

    // Held for 10 cycles, then re-pulsed twice inside HOLD; last request at j=14.
    for (int j = 0; j < 20; j++) held_req[j] = (j < 10) || (j == 12) || (j == 14);
    for (int j = 0; j < 20; j++) begin
      cyc("held_retrigger", j, 1, 1'b1, held_req[j], soft_exp(18, j, SOFT ? 8'd2 : 8'd0));
    end

    // Saturation: 260 more soft resets from a count of 2.
    for (int i = 0; i < 260; i++) begin
      sat_c = ((3 + i) > 255) ? 8'd255 : 8'(3 + i);
      soft_pulse("saturate", SOFT ? sat_c : 8'd0);
    end

    // Parameter corners: SYNC_STAGES=4 with HOLD_CYCLES=1 and 65535.
    exp_edge_q.push_back(6);
    exp_edge_q.push_back(65540);
    c_edge  = -1;
    d_edge  = -1;
    c_pulse = 1'b0;
    d_pulse = 1'b0;
    reset_n = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    for (int k = 1; k <= 65600; k++) begin
      @(posedge clk);
      #1;
      if (c_edge < 0 && rst_c == 1'b0) begin
        c_edge  = k;
        c_pulse = pls_c;
      end
      if (d_edge < 0 && rst_d == 1'b0) begin
        d_edge  = k;
        d_pulse = pls_d;
      end
      if (d_edge > 0 && k >= d_edge + 5) break;
    end
    chk("corner_c_release_edge", 0, 32'(c_edge), 32'(exp_edge_q.pop_front()));
    chk("corner_d_release_edge", 0, 32'(d_edge), 32'(exp_edge_q.pop_front()));
    chk("corner_c_pulse", 0, 32'(c_pulse), 32'(1'b1));
    chk("corner_d_pulse", 0, 32'(d_pulse), 32'(1'b1));
    chk("corner_c_steady", 0, 32'(obs_c), 32'(mk(1'b0, 1'b1, 1'b0, 8'h00)));
    chk("corner_d_no_wrap", 0, 32'(obs_d), 32'(mk(1'b0, 1'b1, 1'b0, 8'h00)));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
